// File: rtl/de_latch_rx_pkg.sv
// Shared decode-stage definitions: RV32I opcodes, instruction field
// positions, FE/DE latch widths and field order, bus canary value.
package de_latch_rx_pkg;

    localparam int unsigned DBITS_DEF    = 32;
    localparam int unsigned INSTBITS_DEF = 32;
    localparam int unsigned CANARY_W_DEF = 16;
    localparam int unsigned REG_IDX_W    = 5;

    localparam logic [15:0] BUS_CANARY_VALUE = 16'hC0DE;

    // Instruction field positions
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    // FE latch, MSB first: inst, pc, pcplus, inst_count, canary
    localparam int unsigned FE_LATCH_W = INSTBITS_DEF + 3 * DBITS_DEF + CANARY_W_DEF;
    // DE latch, MSB first: inst, pc, pcplus, inst_count, rd, rs1, rs2, wr_reg, canary
    localparam int unsigned DE_LATCH_W = INSTBITS_DEF + 3 * DBITS_DEF + 3 * REG_IDX_W + 1
                                       + CANARY_W_DEF;

    function automatic logic [REG_IDX_W-1:0] reg_field(input logic [INSTBITS_DEF-1:0] inst,
                                                        input int unsigned lsb);
        return inst[lsb +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/de_latch_rx_if.sv
// FE->DE latch bus plus the decode-side control and status signals.
interface de_latch_rx_if
    import de_latch_rx_pkg::*;
#(
    parameter int unsigned FE_W = FE_LATCH_W,
    parameter int unsigned DE_W = DE_LATCH_W
);
    logic [FE_W-1:0]      fe_latch_in;
    logic                 flush_in;
    logic                 wb_we;
    logic [REG_IDX_W-1:0] wb_rd;
    logic                 stall_to_fe;
    logic [DE_W-1:0]      de_latch_out;
    logic                 canary_err;

    modport master (
        output fe_latch_in, flush_in, wb_we, wb_rd,
        input  stall_to_fe, de_latch_out, canary_err
    );

    modport slave (
        input  fe_latch_in, flush_in, wb_we, wb_rd,
        output stall_to_fe, de_latch_out, canary_err
    );
endinterface

// File: rtl/de_inst_classify.sv
// Pure combinational RV32I register-use classifier.
module de_inst_classify
    import de_latch_rx_pkg::*;
#(
    parameter int unsigned INSTBITS = INSTBITS_DEF
) (
    input  logic [INSTBITS-1:0]  inst,
    output logic [REG_IDX_W-1:0] rd,
    output logic [REG_IDX_W-1:0] rs1,
    output logic [REG_IDX_W-1:0] rs2,
    output logic                 wr_reg,
    output logic                 uses_rs1,
    output logic                 uses_rs2
);

    // Extract register fields and decide which ones the opcode reads/writes
    always_comb begin
        opcode_e opc;
        logic    writes;
        opc      = opcode_e'(inst[OPC_LSB +: OPC_W]);
        rd       = reg_field(inst[INSTBITS_DEF-1:0], RD_LSB);
        rs1      = reg_field(inst[INSTBITS_DEF-1:0], RS1_LSB);
        rs2      = reg_field(inst[INSTBITS_DEF-1:0], RS2_LSB);
        writes   = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: writes = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                writes   = 1'b1;
                uses_rs1 = 1'b1;
            end
            OPC_OP: begin
                writes   = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
        wr_reg = writes && (rd != '0);
    end

endmodule

// File: rtl/de_latch_rx.sv
// Decode-side receiver of the FE latch bus: unpacks and classifies the
// instruction, tracks pending register writes, stalls fetch on hazards and
// loads the DE latch (bubble on stall/flush).
// Optional macro DE_STAT_EN adds stall_cycles / bubble_cycles counters.
module de_latch_rx
    import de_latch_rx_pkg::*;
#(
    parameter int unsigned          DBITS      = DBITS_DEF,
    parameter int unsigned          INSTBITS   = INSTBITS_DEF,
    parameter int unsigned          CANARY_W   = CANARY_W_DEF,
    parameter logic [CANARY_W-1:0]  CANARY_VAL = CANARY_W'(BUS_CANARY_VALUE),
    parameter int unsigned          SB_CNT_W   = 2
) (
    input logic          clk,
    input logic          reset,
    de_latch_rx_if.slave bus
`ifdef DE_STAT_EN
    ,
    output logic [31:0]  stall_cycles,
    output logic [31:0]  bubble_cycles
`endif
);

    localparam int unsigned DE_W = INSTBITS + 3 * DBITS + 3 * REG_IDX_W + 1 + CANARY_W;
    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

    logic [INSTBITS-1:0]  fe_inst;
    logic [DBITS-1:0]     fe_pc;
    logic [DBITS-1:0]     fe_pcplus;
    logic [DBITS-1:0]     fe_count;
    logic [CANARY_W-1:0]  fe_canary;

    logic [REG_IDX_W-1:0] rd, rs1, rs2;
    logic                 wr_reg, uses_rs1, uses_rs2;
    logic                 fe_valid, hazard, issue;

    logic [SB_CNT_W-1:0]  cnt_q [32];
    logic [SB_CNT_W-1:0]  cnt_d [32];
    logic [DE_W-1:0]      de_latch_q, de_latch_d;
    logic                 canary_err_q, canary_err_d;

    assign {fe_inst, fe_pc, fe_pcplus, fe_count, fe_canary} = bus.fe_latch_in;

    de_inst_classify #(.INSTBITS(INSTBITS)) u_classify (
        .inst     (fe_inst),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .wr_reg   (wr_reg),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // Hazard detection against pre-writeback counters; flush masks the stall
    always_comb begin
        fe_valid = (fe_count != '0);
        hazard   = 1'b0;
        if (fe_valid && !bus.flush_in) begin
            if (uses_rs1 && (cnt_q[rs1] != '0))   hazard = 1'b1;
            if (uses_rs2 && (cnt_q[rs2] != '0))   hazard = 1'b1;
            if (wr_reg && (cnt_q[rd] == CNT_MAX)) hazard = 1'b1;
        end
        issue = fe_valid && !hazard && !bus.flush_in;
    end

    // Next DE latch contents and sticky canary error
    always_comb begin
        de_latch_d   = '0;
        canary_err_d = canary_err_q;
        if (issue) begin
            de_latch_d = {fe_inst, fe_pc, fe_pcplus, fe_count, rd, rs1, rs2, wr_reg, fe_canary};
        end
        if (fe_valid && (fe_canary != CANARY_VAL)) begin
            canary_err_d = 1'b1;
        end
    end

    // Scoreboard update: +1 on issuing write, -1 on writeback, both cancel; x0 pinned at 0
    always_comb begin
        logic inc;
        logic dec;
        inc      = 1'b0;
        dec      = 1'b0;
        cnt_d    = cnt_q;
        cnt_d[0] = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            inc = issue && wr_reg && (rd == REG_IDX_W'(r));
            dec = bus.wb_we && (bus.wb_rd == REG_IDX_W'(r));
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + SB_CNT_W'(1);
            end else if (dec && !inc && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - SB_CNT_W'(1);
            end
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            de_latch_q   <= '0;
            canary_err_q <= 1'b0;
            cnt_q        <= '{default: '0};
        end else begin
            de_latch_q   <= de_latch_d;
            canary_err_q <= canary_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.stall_to_fe  = hazard;
    assign bus.de_latch_out = de_latch_q;
    assign bus.canary_err   = canary_err_q;

`ifdef DE_STAT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] bubble_cycles_q, bubble_cycles_d;

    // Saturating stall and bubble counters
    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        bubble_cycles_d = bubble_cycles_q;
        if (hazard && (stall_cycles_q != '1))  stall_cycles_d  = stall_cycles_q + 32'd1;
        if (!issue && (bubble_cycles_q != '1)) bubble_cycles_d = bubble_cycles_q + 32'd1;
    end

    // Statistics registers with a per-stall-cycle trace line
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q  <= '0;
            bubble_cycles_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            bubble_cycles_q <= bubble_cycles_d;
            if (hazard) begin
                $display("de_latch_rx: stall cycle, total %0d", stall_cycles_d);
            end
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign bubble_cycles = bubble_cycles_q;
`endif

endmodule

// File: tb/tb_de_latch_rx.sv
// Directed self-checking bench for de_latch_rx.
module tb_de_latch_rx;
    import de_latch_rx_pkg::*;

    logic clk = 1'b0;
    logic reset;
    de_latch_rx_if bus ();
`ifdef DE_STAT_EN
    logic [31:0] stall_cycles;
    logic [31:0] bubble_cycles;
`endif

    de_latch_rx dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus)
`ifdef DE_STAT_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_stalls = 0;

    localparam logic [15:0]  CAN           = 16'hC0DE;
    localparam logic [31:0]  ADDI_X5       = 32'h00100293;  // addi x5,x0,1
    localparam logic [31:0]  ADD_X6        = 32'h00528333;  // add x6,x5,x5
    localparam logic [31:0]  ADDI_X7       = 32'h00100393;  // addi x7,x0,1
    localparam logic [31:0]  ADDI_X9       = 32'h00100493;  // addi x9,x0,1
    localparam logic [31:0]  ADD_X10       = 32'h00048533;  // add x10,x9,x0
    localparam logic [31:0]  ADD_X11       = 32'h005305B3;  // add x11,x6,x5
    localparam logic [31:0]  NOP           = 32'h00000013;  // addi x0,x0,0

    function automatic logic [143:0] mk_fe(input logic [31:0] inst, input logic [31:0] pc,
                                           input logic [31:0] cnt, input logic [15:0] can);
        return {inst, pc, pc + 32'd4, cnt, can};
    endfunction

    function automatic logic [159:0] mk_de(input logic [31:0] inst, input logic [31:0] pc,
                                           input logic [31:0] cnt, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic wr, input logic [15:0] can);
        return {inst, pc, pc + 32'd4, cnt, rd, rs1, rs2, wr, can};
    endfunction

    task automatic drive(input logic [143:0] fe, input logic fl, input logic we,
                         input logic [4:0] wrd);
        bus.fe_latch_in = fe;
        bus.flush_in    = fl;
        bus.wb_we       = we;
        bus.wb_rd       = wrd;
        #1;
    endtask

    task automatic tick(input bit stalled);
        if (stalled) exp_stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [159:0] zero_de;
        zero_de = '0;
        reset = 1'b0;
        drive('0, 1'b0, 1'b0, 5'd0);
        tick(0);
        tick(0);
        total++; if (bus.de_latch_out !== zero_de) begin bad++; $display("FAIL reset_de: got %h want %h", bus.de_latch_out, zero_de); end
        total++; if (bus.stall_to_fe !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall_to_fe); end
        total++; if (bus.canary_err !== 1'b0) begin bad++; $display("FAIL reset_canary: got %b want 0", bus.canary_err); end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive('0, 1'b0, 1'b0, 5'd0);
            tick(0);
            total++; if (bus.de_latch_out !== zero_de) begin bad++; $display("FAIL bubble_out_%0d: got %h want %h", i, bus.de_latch_out, zero_de); end
        end
    endtask

    task automatic test_raw_hazard;
        logic [159:0] exp;
        drive(mk_fe(ADDI_X5, 32'h100, 32'd1, CAN), 1'b0, 1'b0, 5'd0);
        total++; if (bus.stall_to_fe !== 1'b0) begin bad++; $display("FAIL raw_addi_stall: got %b want 0", bus.stall_to_fe); end
        tick(0);
        exp = mk_de(ADDI_X5, 32'h100, 32'd1, 5'd5, 5'd0, 5'd1, 1'b1, CAN);
        total++; if (bus.de_latch_out !== exp) begin bad++; $display("FAIL raw_addi_issue: got %h want %h", bus.de_latch_out, exp); end
        drive(mk_fe(ADD_X6, 32'h104, 32'd2, CAN), 1'b0, 1'b0, 5'd0);
        total++; if (bus.stall_to_fe !== 1'b1) begin bad++; $display("FAIL raw_add_stall: got %b want 1", bus.stall_to_fe); end
        tick(1);
        total++; if (bus.de_latch_out !== 160'd0) begin bad++; $display("FAIL raw_bubble: got %h want 0", bus.de_latch_out); end
        tick(1);
        total++; if (bus.stall_to_fe !== 1'b1) begin bad++; $display("FAIL raw_still_stall: got %b want 1", bus.stall_to_fe); end
        drive(mk_fe(ADD_X6, 32'h104, 32'd2, CAN), 1'b0, 1'b1, 5'd5);
        total++; if (bus.stall_to_fe !== 1'b1) begin bad++; $display("FAIL raw_wb_same_cycle: got %b want 1", bus.stall_to_fe); end
        tick(1);
        drive(mk_fe(ADD_X6, 32'h104, 32'd2, CAN), 1'b0, 1'b0, 5'd0);
        total++; if (bus.stall_to_fe !== 1'b0) begin bad++; $display("FAIL raw_release: got %b want 0", bus.stall_to_fe); end
        tick(0);
        exp = mk_de(ADD_X6, 32'h104, 32'd2, 5'd6, 5'd5, 5'd5, 1'b1, CAN);
        total++; if (bus.de_latch_out !== exp) begin bad++; $display("FAIL raw_add_issue: got %h want %h", bus.de_latch_out, exp); end
        drive('0, 1'b0, 1'b1, 5'd6);
        tick(0);
        drive('0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_saturate;
        logic [159:0] exp;
        for (int k = 0; k < 3; k++) begin
            drive(mk_fe(ADDI_X7, 32'h200 + 32'(4 * k), 32'(3 + k), CAN), 1'b0, 1'b0, 5'd0);
            total++; if (bus.stall_to_fe !== 1'b0) begin bad++; $display("FAIL sat_issue_%0d: got %b want 0", k, bus.stall_to_fe); end
            tick(0);
        end
        drive(mk_fe(ADDI_X7, 32'h20C, 32'd6, CAN), 1'b0, 1'b0, 5'd0);
        total++; if (bus.stall_to_fe !== 1'b1) begin bad++; $display("FAIL sat_full_stall: got %b want 1", bus.stall_to_fe); end
        tick(1);
        drive(mk_fe(ADDI_X7, 32'h20C, 32'd6, CAN), 1'b0, 1'b1, 5'd7);
        total++; if (bus.stall_to_fe !== 1'b1) begin bad++; $display("FAIL sat_wb_same_cycle: got %b want 1", bus.stall_to_fe); end
        tick(1);
        drive(mk_fe(ADDI_X7, 32'h20C, 32'd6, CAN), 1'b0, 1'b0, 5'd0);
        total++; if (bus.stall_to_fe !== 1'b0) begin bad++; $display("FAIL sat_release: got %b want 0", bus.stall_to_fe); end
        tick(0);
        exp = mk_de(ADDI_X7, 32'h20C, 32'd6, 5'd7, 5'd0, 5'd1, 1'b1, CAN);
        total++; if (bus.de_latch_out !== exp) begin bad++; $display("FAIL sat_issue_last: got %h want %h", bus.de_latch_out, exp); end
        // drain x7 from 3 to 0, then one extra writeback at 0
        for (int k = 0; k < 4; k++) begin
            drive('0, 1'b0, 1'b1, 5'd7);
            tick(0);
        end
        drive(mk_fe(ADDI_X7, 32'h210, 32'd7, CAN), 1'b0, 1'b0, 5'd0);
        total++; if (bus.stall_to_fe !== 1'b0) begin bad++; $display("FAIL sat_no_wrap: got %b want 0", bus.stall_to_fe); end
        tick(0);
        drive('0, 1'b0, 1'b1, 5'd7);
        tick(0);
        drive('0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_same_cycle_wb;
        logic [159:0] exp;
        drive(mk_fe(ADDI_X9, 32'h300, 32'd10, CAN), 1'b0, 1'b0, 5'd0);
        tick(0);
        drive(mk_fe(ADDI_X9, 32'h304, 32'd11, CAN), 1'b0, 1'b1, 5'd9);
        total++; if (bus.stall_to_fe !== 1'b0) begin bad++; $display("FAIL swb_issue_stall: got %b want 0", bus.stall_to_fe); end
        tick(0);
        exp = mk_de(ADDI_X9, 32'h304, 32'd11, 5'd9, 5'd0, 5'd1, 1'b1, CAN);
        total++; if (bus.de_latch_out !== exp) begin bad++; $display("FAIL swb_issue: got %h want %h", bus.de_latch_out, exp); end
        drive(mk_fe(ADD_X10, 32'h308, 32'd12, CAN), 1'b0, 1'b0, 5'd0);
        total++; if (bus.stall_to_fe !== 1'b1) begin bad++; $display("FAIL swb_cnt_kept: got %b want 1", bus.stall_to_fe); end
        tick(1);
        drive(mk_fe(ADD_X10, 32'h308, 32'd12, CAN), 1'b0, 1'b1, 5'd9);
        tick(1);
        drive(mk_fe(ADD_X10, 32'h308, 32'd12, CAN), 1'b0, 1'b0, 5'd0);
        total++; if (bus.stall_to_fe !== 1'b0) begin bad++; $display("FAIL swb_cnt_one: got %b want 0", bus.stall_to_fe); end
        tick(0);
        exp = mk_de(ADD_X10, 32'h308, 32'd12, 5'd10, 5'd9, 5'd0, 1'b1, CAN);
        total++; if (bus.de_latch_out !== exp) begin bad++; $display("FAIL swb_reader_issue: got %h want %h", bus.de_latch_out, exp); end
        drive('0, 1'b0, 1'b1, 5'd10);
        tick(0);
        drive('0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_flush;
        logic [159:0] exp;
        drive(mk_fe(ADDI_X5, 32'h400, 32'd20, CAN), 1'b0, 1'b0, 5'd0);
        tick(0);
        drive(mk_fe(ADD_X6, 32'h404, 32'd21, CAN), 1'b0, 1'b0, 5'd0);
        total++; if (bus.stall_to_fe !== 1'b1) begin bad++; $display("FAIL flush_pre_stall: got %b want 1", bus.stall_to_fe); end
        tick(1);
        drive(mk_fe(ADD_X6, 32'h404, 32'd21, CAN), 1'b1, 1'b1, 5'd5);
        total++; if (bus.stall_to_fe !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", bus.stall_to_fe); end
        tick(0);
        total++; if (bus.de_latch_out !== 160'd0) begin bad++; $display("FAIL flush_bubble: got %h want 0", bus.de_latch_out); end
        // reads x6 (must be untouched by the flushed add) and x5 (drained during flush)
        drive(mk_fe(ADD_X11, 32'h408, 32'd22, CAN), 1'b0, 1'b0, 5'd0);
        total++; if (bus.stall_to_fe !== 1'b0) begin bad++; $display("FAIL flush_no_side_effect: got %b want 0", bus.stall_to_fe); end
        tick(0);
        exp = mk_de(ADD_X11, 32'h408, 32'd22, 5'd11, 5'd6, 5'd5, 1'b1, CAN);
        total++; if (bus.de_latch_out !== exp) begin bad++; $display("FAIL flush_next_issue: got %h want %h", bus.de_latch_out, exp); end
        drive('0, 1'b0, 1'b1, 5'd11);
        tick(0);
        drive('0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_canary;
        logic [159:0] exp;
        drive(mk_fe(32'h0, 32'h0, 32'd0, 16'h1234), 1'b0, 1'b0, 5'd0);
        tick(0);
        total++; if (bus.canary_err !== 1'b0) begin bad++; $display("FAIL canary_invalid_ignored: got %b want 0", bus.canary_err); end
        drive(mk_fe(NOP, 32'h500, 32'd30, 16'h0000), 1'b0, 1'b0, 5'd0);
        tick(0);
        total++; if (bus.canary_err !== 1'b1) begin bad++; $display("FAIL canary_set: got %b want 1", bus.canary_err); end
        exp = mk_de(NOP, 32'h500, 32'd30, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0000);
        total++; if (bus.de_latch_out !== exp) begin bad++; $display("FAIL canary_passthru: got %h want %h", bus.de_latch_out, exp); end
        drive(mk_fe(NOP, 32'h504, 32'd31, CAN), 1'b0, 1'b0, 5'd0);
        tick(0);
        drive('0, 1'b0, 1'b0, 5'd0);
        tick(0);
        total++; if (bus.canary_err !== 1'b1) begin bad++; $display("FAIL canary_sticky: got %b want 1", bus.canary_err); end
    endtask

    task automatic test_stats;
`ifdef DE_STAT_EN
        total++; if (stall_cycles !== 32'(exp_stalls)) begin bad++; $display("FAIL stat_stalls: got %0d want %0d", stall_cycles, exp_stalls); end
`endif
    endtask

    task automatic test_reset_mid_stall;
        logic [159:0] exp;
        drive(mk_fe(ADDI_X5, 32'h600, 32'd40, CAN), 1'b0, 1'b0, 5'd0);
        tick(0);
        drive(mk_fe(ADD_X6, 32'h604, 32'd41, CAN), 1'b0, 1'b0, 5'd0);
        total++; if (bus.stall_to_fe !== 1'b1) begin bad++; $display("FAIL rst_pre_stall: got %b want 1", bus.stall_to_fe); end
        reset = 1'b0;
        tick(0);
        total++; if (bus.stall_to_fe !== 1'b0) begin bad++; $display("FAIL rst_sb_cleared: got %b want 0", bus.stall_to_fe); end
        total++; if (bus.de_latch_out !== 160'd0) begin bad++; $display("FAIL rst_de: got %h want 0", bus.de_latch_out); end
        total++; if (bus.canary_err !== 1'b0) begin bad++; $display("FAIL rst_canary: got %b want 0", bus.canary_err); end
        reset = 1'b1;
        tick(0);
        exp = mk_de(ADD_X6, 32'h604, 32'd41, 5'd6, 5'd5, 5'd5, 1'b1, CAN);
        total++; if (bus.de_latch_out !== exp) begin bad++; $display("FAIL rst_post_issue: got %h want %h", bus.de_latch_out, exp); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_raw_hazard();
        test_saturate();
        test_same_cycle_wb();
        test_flush();
        test_canary();
        test_stats();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
